// File: rtl/l2_vec_accum.sv
// l2_vec_accum: streaming sum-of-squares over vectors of up to VEC_LEN elements.
// Three stages: S1 registers the element, S2 registers its square, and S3 holds
// the accumulator, the element counter and the result register.
// A pending result that the consumer has not taken freezes the whole pipeline.
// Optional feature macro: L2_VEC_ACCUM_SQRT_EN. When it is defined, each
// terminated sum goes through a bit-serial integer square root before it is
// reported.
module l2_vec_accum #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 16,
    parameter int SIGNED  = 0,
    localparam int ACC_W  = 2*DATA_W + $clog2(VEC_LEN),
    localparam int CNT_W  = $clog2(VEC_LEN+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic              valid_in,
    input  logic              last_in,
    output logic              ready_in,
    output logic [ACC_W-1:0]  f,
    output logic [CNT_W-1:0]  count_out,
    output logic              valid_out,
    input  logic              ready_out
);
    localparam int SQ_W = 2*DATA_W;

    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic              s1_v_q, s1_v_d, s1_last_q, s1_last_d;
    logic [SQ_W-1:0]   s2_sq_q, s2_sq_d;
    logic              s2_v_q, s2_v_d, s2_last_q, s2_last_d;
    logic [ACC_W-1:0]  acc_q, acc_d, f_q, f_d, sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d, count_q, count_d;
    logic              valid_out_q, valid_out_d;
    logic [SQ_W-1:0]   sq_w;
    logic              stall, busy, advance, term;

    // The square is formed from the S1 element; a signed square is never negative.
    generate
        if (SIGNED != 0) begin : g_sq_signed
            logic signed [SQ_W-1:0] sq_s;
            assign sq_s = $signed(s1_a_q) * $signed(s1_a_q);
            assign sq_w = sq_s;
        end else begin : g_sq_unsigned
            assign sq_w = SQ_W'(s1_a_q) * SQ_W'(s1_a_q);
        end
    endgenerate

    assign stall     = valid_out_q && !ready_out;
    assign advance   = !stall && !busy;
    assign ready_in  = advance;
    assign f         = f_q;
    assign count_out = count_q;
    assign valid_out = valid_out_q;

`ifdef L2_VEC_ACCUM_SQRT_EN
    localparam int               RW       = 2*((ACC_W+1)/2);
    localparam logic [RW-1:0]    BIT_INIT = RW'(1) << (RW-2);
    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_BUSY  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [RW-1:0] rem_q, rem_d, root_q, root_d, bit_q, bit_d, trial, root_nx;

    assign busy = (state_q == ST_BUSY);
`else
    assign busy = 1'b0;
`endif

    // Next-state logic for the pipeline, the accumulator and the result.
    always_comb begin
        s1_a_d      = s1_a_q;
        s1_v_d      = s1_v_q;
        s1_last_d   = s1_last_q;
        s2_sq_d     = s2_sq_q;
        s2_v_d      = s2_v_q;
        s2_last_d   = s2_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        f_d         = f_q;
        count_d     = count_q;
        valid_out_d = valid_out_q;
        sum         = acc_q + ACC_W'(s2_sq_q);
        term        = s2_v_q && (s2_last_q || (cnt_q == CNT_W'(VEC_LEN-1)));
`ifdef L2_VEC_ACCUM_SQRT_EN
        state_d     = state_q;
        rem_d       = rem_q;
        root_d      = root_q;
        bit_d       = bit_q;
        trial       = root_q + bit_q;
        root_nx     = root_q >> 1;
`endif
        if (advance) begin
            s1_v_d    = valid_in;
            s1_a_d    = a;
            s1_last_d = last_in;
            s2_v_d    = s1_v_q;
            s2_sq_d   = sq_w;
            s2_last_d = s1_last_q;
            if (s2_v_q) begin
                if (term) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
        // Once not stalled, any result on the port has been taken this edge.
        if (!stall) begin
            valid_out_d = 1'b0;
        end
`ifdef L2_VEC_ACCUM_SQRT_EN
        if (advance && term) begin
            state_d = ST_BUSY;
            rem_d   = RW'(sum);
            root_d  = '0;
            bit_d   = BIT_INIT;
            count_d = cnt_q + CNT_W'(1);
        end
        if (busy) begin
            if (rem_q >= trial) begin
                rem_d   = rem_q - trial;
                root_nx = (root_q >> 1) + bit_q;
            end
            root_d = root_nx;
            bit_d  = bit_q >> 2;
            if (bit_q == RW'(1)) begin
                state_d     = ST_IDLE;
                f_d         = ACC_W'(root_nx);
                valid_out_d = 1'b1;
            end
        end
`else
        if (advance && term) begin
            f_d         = sum;
            count_d     = cnt_q + CNT_W'(1);
            valid_out_d = 1'b1;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_a_q      <= '0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_sq_q     <= '0;
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            f_q         <= '0;
            count_q     <= '0;
            valid_out_q <= 1'b0;
`ifdef L2_VEC_ACCUM_SQRT_EN
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            root_q      <= '0;
            bit_q       <= '0;
`endif
        end else begin
            s1_a_q      <= s1_a_d;
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
            s2_sq_q     <= s2_sq_d;
            s2_v_q      <= s2_v_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            f_q         <= f_d;
            count_q     <= count_d;
            valid_out_q <= valid_out_d;
`ifdef L2_VEC_ACCUM_SQRT_EN
            state_q     <= state_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            bit_q       <= bit_d;
`endif
        end
    end
endmodule

// File: tb/tb_l2_vec_accum.sv
// Bench for l2_vec_accum (default build): a table of vectors plus hand-written
// latency, stall, reset, auto-termination and signed sequences.
// Expected results are queued when an element closing a vector is accepted.
// They are compared when the result handshake occurs.
module tb_l2_vec_accum;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a;
    logic        valid_in, last_in, ready_in, valid_out, ready_out;
    logic [19:0] f;
    logic [4:0]  count_out;

    logic [7:0]  s_a;
    logic        s_valid, s_last, s_ready_in, s_vout;
    logic [19:0] s_f;
    logic [4:0]  s_cnt;

    always #5 clk = ~clk;

    l2_vec_accum dut (
        .clk(clk), .reset(reset), .a(a), .valid_in(valid_in), .last_in(last_in),
        .ready_in(ready_in), .f(f), .count_out(count_out), .valid_out(valid_out),
        .ready_out(ready_out)
    );

    l2_vec_accum #(.SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .a(s_a), .valid_in(s_valid), .last_in(s_last),
        .ready_in(s_ready_in), .f(s_f), .count_out(s_cnt), .valid_out(s_vout),
        .ready_out(1'b1)
    );

    typedef struct {
        logic [7:0] a;
        bit         last;
        bit         ends;
        int         ef;
        int         ec;
    } vec_t;

    typedef struct {
        int ef;
        int ec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive one element at posedge+2 and hold it until accepted; returns at posedge+2.
    task automatic send(input logic [7:0] av, input bit lst, input bit ends, input int ef, input int ec);
        int guard = 0;
        a = av; last_in = lst; valid_in = 1'b1;
        #1;
        while (!ready_in && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        if (!ready_in) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready_in got 0 expected 1");
        end else begin
            if (ends) begin
                exp_t e;
                e.ef = ef; e.ec = ec;
                sb.push_back(e);
            end
            $display("send a=%0d last=%0d", av, lst);
        end
        @(posedge clk); #2;
        valid_in = 1'b0;
    endtask

    // Result monitor: compares at the negedge before a handshake edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset && valid_out && ready_out) begin
            $display("result f=%0d count=%0d", f, count_out);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got f=%0d expected no result", f);
            end else begin
                e = sb.pop_front();
                chk("result_f", 64'(f), 64'(e.ef));
                chk("result_count", 64'(count_out), 64'(e.ec));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{a: 8'd3,   last: 1'b0, ends: 1'b0, ef: 0,     ec: 0};
        tbl[1] = '{a: 8'd4,   last: 1'b1, ends: 1'b1, ef: 25,    ec: 2};
        tbl[2] = '{a: 8'd10,  last: 1'b0, ends: 1'b0, ef: 0,     ec: 0};
        tbl[3] = '{a: 8'd20,  last: 1'b0, ends: 1'b0, ef: 0,     ec: 0};
        tbl[4] = '{a: 8'd30,  last: 1'b1, ends: 1'b1, ef: 1400,  ec: 3};
        tbl[5] = '{a: 8'd255, last: 1'b1, ends: 1'b1, ef: 65025, ec: 1};
        tbl[6] = '{a: 8'd0,   last: 1'b1, ends: 1'b1, ef: 0,     ec: 1};
        tbl[7] = '{a: 8'd12,  last: 1'b1, ends: 1'b1, ef: 144,   ec: 1};

        reset = 1'b0; a = '0; valid_in = 1'b0; last_in = 1'b0; ready_out = 1'b1;
        s_a = '0; s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_f", 64'(f), 64'd0);
        chk("reset_count", 64'(count_out), 64'd0);
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_ready_in", 64'(ready_in), 64'd1);
        reset = 1'b1;
        @(posedge clk); #2;

        // Latency: last element accepted at edge k, result visible from edge k+2.
        send(8'd3, 1'b0, 1'b0, 0, 0);
        send(8'd4, 1'b1, 1'b1, 25, 2);
        chk("latency_k", 64'(valid_out), 64'd0);
        @(posedge clk); #2;
        chk("latency_k1", 64'(valid_out), 64'd0);
        @(posedge clk); #2;
        chk("latency_k2", 64'(valid_out), 64'd1);
        chk("latency_f", 64'(f), 64'd25);

        // Table-driven vectors, streamed continuously.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].last, tbl[i].ends, tbl[i].ef, tbl[i].ec);
        end

        // Auto-termination at VEC_LEN, then a fresh 1-element vector.
        for (int i = 0; i < 16; i++) begin
            send(8'd255, 1'b0, (i == 15), 1040400, 16);
        end
        send(8'd9, 1'b1, 1'b1, 81, 1);
        repeat (4) @(posedge clk);
        #2;

        // Back-pressure: result pending while the source keeps offering data.
        ready_out = 1'b0;
        send(8'd3, 1'b0, 1'b0, 0, 0);
        send(8'd4, 1'b1, 1'b1, 25, 2);
        a = 8'd1; last_in = 1'b0; valid_in = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("stall_ready_in_first", 64'(ready_in), 64'd0);
        last_in = 1'b1;
        begin
            exp_t e;
            e.ef = 3; e.ec = 3;
            sb.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("stall_ready_in", 64'(ready_in), 64'd0);
            chk("stall_f", 64'(f), 64'd25);
            chk("stall_count", 64'(count_out), 64'd2);
        end
        ready_out = 1'b1;
        #1;
        chk("release_ready_in", 64'(ready_in), 64'd1);
        @(posedge clk); #2;
        valid_in = 1'b0; last_in = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // Reset mid-vector discards partial state.
        send(8'd2, 1'b0, 1'b0, 0, 0);
        send(8'd2, 1'b0, 1'b0, 0, 0);
        send(8'd2, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #2;
        chk("midreset_f", 64'(f), 64'd0);
        chk("midreset_count", 64'(count_out), 64'd0);
        chk("midreset_valid_out", 64'(valid_out), 64'd0);
        chk("midreset_ready_in", 64'(ready_in), 64'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        send(8'd2, 1'b1, 1'b1, 4, 1);
        repeat (4) @(posedge clk);
        #2;

        // Single-element vectors back-to-back give results on consecutive cycles.
        send(8'd5, 1'b1, 1'b1, 25, 1);
        send(8'd6, 1'b1, 1'b1, 36, 1);
        send(8'd7, 1'b1, 1'b1, 49, 1);
        chk("b2b_valid0", 64'(valid_out), 64'd1);
        chk("b2b_f0", 64'(f), 64'd25);
        @(posedge clk); #2;
        chk("b2b_valid1", 64'(valid_out), 64'd1);
        chk("b2b_f1", 64'(f), 64'd36);
        @(posedge clk); #2;
        chk("b2b_valid2", 64'(valid_out), 64'd1);
        chk("b2b_f2", 64'(f), 64'd49);

        // Signed instance: {-128, 127} and {-1}.
        chk("sgn_ready_in", 64'(s_ready_in), 64'd1);
        s_valid = 1'b1; s_a = 8'h80; s_last = 1'b0;
        @(posedge clk); #2;
        s_a = 8'd127; s_last = 1'b1;
        @(posedge clk); #2;
        s_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("sgn_valid", 64'(s_vout), 64'd1);
        chk("sgn_f", 64'(s_f), 64'd32513);
        chk("sgn_count", 64'(s_cnt), 64'd2);
        s_valid = 1'b1; s_a = 8'hFF; s_last = 1'b1;
        @(posedge clk); #2;
        s_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("sgn_neg1_f", 64'(s_f), 64'd1);
        chk("sgn_neg1_count", 64'(s_cnt), 64'd1);

        repeat (6) @(posedge clk);
        #2;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
